// File: rtl/bcd_scan_display_if.sv
// Display bus between a BCD digit source and the scanned seven-segment driver.
interface bcd_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    bcd_err;

    // Digit source side
    modport master (
        output digits_in,
        output blank_lz,
        input  seg,
        input  an,
        input  bcd_err
    );

    // Display driver side
    modport slave (
        input  digits_in,
        input  blank_lz,
        output seg,
        output an,
        output bcd_err
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS packed BCD digits.
// The digit vector is snapshotted once per frame so counter ripples never tear
// a frame; optional leading-zero blanking; invalid codes show a dash.
module bcd_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input logic               clk,
    input logic               rst_n,
    bcd_scan_display_if.slave disp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam bit INV = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = INV ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = INV ? '1 : '0;

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    bcd_err_q, bcd_err_d;

    logic                    tick;
    logic                    blank;
    logic [3:0]              cur_digit;
    logic [6:0]              seg_act;
    logic [NUM_DIGITS-1:0]   an_act;

    // Prescaler, scan index and once-per-frame snapshot of the digit vector
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        if (tick) begin
            if (idx_q == IDX_LAST) begin
                idx_d    = '0;
                shadow_d = disp.digits_in;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Select current digit, decide blanking, decode and apply output polarity
    always_comb begin
        cur_digit = '0;
        an_act    = '0;
        // Blanked only if this digit and every more-significant digit is zero;
        // digit 0 is never blanked. Invalid codes are nonzero so never blank.
        blank     = disp.blank_lz && (idx_q != '0);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = shadow_q[4*i +: 4];
                an_act[i] = 1'b1;
            end
            if ((IDX_W'(i) >= idx_q) && (shadow_q[4*i +: 4] != 4'd0)) begin
                blank = 1'b0;
            end
        end

        // Active-sense segments, bit order g..a
        case (cur_digit)
            4'd0:    seg_act = 7'h3F;
            4'd1:    seg_act = 7'h06;
            4'd2:    seg_act = 7'h5B;
            4'd3:    seg_act = 7'h4F;
            4'd4:    seg_act = 7'h66;
            4'd5:    seg_act = 7'h6D;
            4'd6:    seg_act = 7'h7D;
            4'd7:    seg_act = 7'h07;
            4'd8:    seg_act = 7'h7F;
            4'd9:    seg_act = 7'h6F;
            default: seg_act = 7'h40;
        endcase
        bcd_err_d = (cur_digit > 4'd9);

        if (blank) begin
            seg_act = '0;
            an_act  = '0;
        end

        seg_d = INV ? ~seg_act : seg_act;
        an_d  = INV ? ~an_act  : an_act;
    end

    // State and registered outputs, async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
            bcd_err_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            bcd_err_q <= bcd_err_d;
        end
    end

    assign disp.seg     = seg_q;
    assign disp.an      = an_q;
    assign disp.bcd_err = bcd_err_q;
endmodule
